// File: rtl/poly_mul_seq.sv
// Product-scanning sequencer for an N x N coefficient polynomial multiply.
// One shared MAC slot, external operand read ports, coefficient stream with handshake.
module poly_mul_seq #(
    parameter  int unsigned N  = 4,
    parameter  int unsigned W  = 4,
    localparam int unsigned AW = $clog2(N),
    localparam int unsigned KW = $clog2(2 * N - 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW-1:0] o_a_addr,
    input  logic [W-1:0]  i_a_data,
    output logic [AW-1:0] o_b_addr,
    input  logic [W-1:0]  i_b_data,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [KW-1:0] o_out_idx,
    output logic [W-1:0]  o_out_coeff
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [KW-1:0] K_LAST = KW'(2 * N - 2);

    state_t        r_state, w_state_nxt;
    logic [KW-1:0] r_k, w_k_nxt;
    logic [AW-1:0] r_i, w_i_nxt;
    logic [W-1:0]  r_acc, w_acc_nxt;

    logic [AW-1:0] w_i_lo, w_i_hi, w_b_idx;
    logic [KW-1:0] w_k_inc;
    logic [W-1:0]  w_prod;

    // Lowest valid A index for coefficient k: max(0, k-N+1).
    function automatic logic [AW-1:0] f_i_lo(input logic [KW-1:0] k);
        if (k >= KW'(N)) return AW'(k - KW'(N - 1));
        return '0;
    endfunction

    assign w_i_lo  = f_i_lo(r_k);
    assign w_i_hi  = (r_k < KW'(N)) ? AW'(r_k) : AW'(N - 1);
    assign w_b_idx = AW'(r_k - KW'(r_i));
    assign w_k_inc = r_k + KW'(1);
    assign w_prod  = i_a_data * i_b_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_i     <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_i     <= w_i_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_i_nxt     = r_i;
        w_acc_nxt   = r_acc;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_MAC;
                    w_k_nxt     = '0;
                    w_i_nxt     = '0;
                    w_acc_nxt   = '0;
                end
            end
            ST_MAC: begin
                // First term of a coefficient overwrites the previous coefficient's sum.
                w_acc_nxt = (r_i == w_i_lo) ? w_prod : W'(r_acc + w_prod);
                if (r_i == w_i_hi) w_state_nxt = ST_EMIT;
                else               w_i_nxt     = r_i + AW'(1);
            end
            ST_EMIT: begin
                if (i_out_ready) begin
                    if (r_k == K_LAST) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_MAC;
                        w_k_nxt     = w_k_inc;
                        w_i_nxt     = f_i_lo(w_k_inc);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_k_nxt     = '0;
                w_i_nxt     = '0;
                w_acc_nxt   = '0;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs registered from next-state values so they line up with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_a_addr    <= '0;
            o_b_addr    <= '0;
            o_out_valid <= 1'b0;
            o_out_idx   <= '0;
            o_out_coeff <= '0;
        end else begin
            o_busy      <= (w_state_nxt != ST_IDLE);
            o_done      <= (w_state_nxt == ST_DONE);
            o_a_addr    <= (w_state_nxt == ST_MAC)  ? w_i_nxt : '0;
            o_b_addr    <= (w_state_nxt == ST_MAC)  ? AW'(w_k_nxt - KW'(w_i_nxt)) : '0;
            o_out_valid <= (w_state_nxt == ST_EMIT);
            o_out_idx   <= (w_state_nxt == ST_EMIT) ? w_k_nxt : '0;
            o_out_coeff <= (w_state_nxt == ST_EMIT) ? w_acc_nxt : '0;
        end
    end

    // Address into operand B is only consumed in MAC; keep the comb value referenced for clarity.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, w_b_idx};

endmodule

// File: tb/tb_poly_mul_seq.sv
// Directed table-driven bench for poly_mul_seq (N=4, W=4) with backpressure,
// mid-run reset and start-handling sequences.
module tb_poly_mul_seq;

    logic       i_clk;
    logic       i_reset;
    logic       i_start;
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_a_addr;
    logic [3:0] i_a_data;
    logic [1:0] o_b_addr;
    logic [3:0] i_b_data;
    logic       o_out_valid;
    logic       i_out_ready;
    logic [2:0] o_out_idx;
    logic [3:0] o_out_coeff;

    logic [3:0] mem_a [4];
    logic [3:0] mem_b [4];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int a [4];
        int b [4];
        int c [7];
    } vec_t;

    vec_t vecs [5];

    poly_mul_seq #(.N(4), .W(4)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_a_addr    (o_a_addr),
        .i_a_data    (i_a_data),
        .o_b_addr    (o_b_addr),
        .i_b_data    (i_b_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_idx   (o_out_idx),
        .o_out_coeff (o_out_coeff)
    );

    assign i_a_data = mem_a[o_a_addr];
    assign i_b_data = mem_b[o_b_addr];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One multiplication, starting from a negedge in IDLE and ending on the negedge
    // after the done pulse. Optional stall at stall_k, stray start at pulse_at,
    // or start held high for the whole run.
    task automatic run(input int v, input int stall_k, input int stall_n,
                       input int pulse_at, input bit hold);
        int  cyc;
        int  exp_idx;
        int  stalled;
        bit  got_done;
        for (int j = 0; j < 4; j++) begin
            mem_a[j] = 4'(vecs[v].a[j]);
            mem_b[j] = 4'(vecs[v].b[j]);
        end
        i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        if (!hold) i_start = 1'b0;
        cyc      = 1;
        exp_idx  = 0;
        stalled  = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            if (cyc == 1) begin
                chk("busy_first_mac", int'(o_busy), 1);
                chk("addr_first_mac", int'(o_a_addr) + int'(o_b_addr), 0);
            end
            i_out_ready = 1'b1;
            if (pulse_at == cyc) i_start = 1'b1;
            else if (!hold)      i_start = 1'b0;
            if (o_out_valid) begin
                chk("out_idx", int'(o_out_idx), exp_idx);
                chk($sformatf("coeff[%0d] vec%0d", exp_idx, v), int'(o_out_coeff),
                    vecs[v].c[exp_idx < 7 ? exp_idx : 6]);
                chk("addr_zero_emit", int'(o_a_addr) + int'(o_b_addr), 0);
                if (exp_idx == stall_k && stalled < stall_n) begin
                    i_out_ready = 1'b0;
                    stalled++;
                end else begin
                    exp_idx++;
                end
            end else if (o_done) begin
                got_done = 1'b1;
                chk("done_cycle", cyc, 24 + stall_n);
                chk("coeff_count", exp_idx, 7);
            end else begin
                chk("mac_busy", int'(o_busy), 1);
                chk("mac_addr_sum", int'(o_a_addr) + int'(o_b_addr), exp_idx);
            end
            if (!got_done) begin
                @(negedge i_clk);
                cyc++;
            end
        end
        if (!got_done) chk("done_timeout", 0, 1);
        @(negedge i_clk);
        chk("busy_after_done", int'(o_busy), 0);
        chk("done_one_cycle", int'(o_done), 0);
    endtask

    initial begin
        vecs[0] = '{a: '{2, 3, 0, 0},     b: '{1, 1, 0, 0},     c: '{2, 5, 3, 0, 0, 0, 0}};
        vecs[1] = '{a: '{1, 2, 3, 4},     b: '{5, 6, 7, 8},     c: '{5, 0, 2, 12, 13, 4, 0}};
        vecs[2] = '{a: '{15, 15, 15, 15}, b: '{15, 15, 15, 15}, c: '{1, 2, 3, 4, 3, 2, 1}};
        vecs[3] = '{a: '{1, 0, 0, 0},     b: '{7, 9, 11, 13},   c: '{7, 9, 11, 13, 0, 0, 0}};
        vecs[4] = '{a: '{0, 0, 0, 1},     b: '{1, 2, 3, 4},     c: '{0, 0, 0, 1, 2, 3, 4}};

        for (int j = 0; j < 4; j++) begin
            mem_a[j] = '0;
            mem_b[j] = '0;
        end
        i_reset     = 1'b1;
        i_start     = 1'b0;
        i_out_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("rst_busy",  int'(o_busy), 0);
        chk("rst_done",  int'(o_done), 0);
        chk("rst_valid", int'(o_out_valid), 0);
        chk("rst_idx",   int'(o_out_idx), 0);
        chk("rst_coeff", int'(o_out_coeff), 0);
        chk("rst_addr",  int'(o_a_addr) + int'(o_b_addr), 0);
        i_reset = 1'b0;
        @(negedge i_clk);

        for (int v = 0; v < 5; v++) run(v, -1, 0, -1, 1'b0);

        // Backpressure: three stalled cycles on coefficient 3.
        run(1, 3, 3, -1, 1'b0);

        // Stray start while busy must not disturb the run.
        run(2, -1, 0, 10, 1'b0);

        // Mid-run reset during MAC of k=2 (cycles t0+6..t0+8).
        mem_a = '{4'd1, 4'd2, 4'd3, 4'd4};
        mem_b = '{4'd5, 4'd6, 4'd7, 4'd8};
        i_start = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (6) @(negedge i_clk);
        chk("pre_reset_busy", int'(o_busy), 1);
        i_reset = 1'b1;
        @(negedge i_clk);
        chk("abort_busy",  int'(o_busy), 0);
        chk("abort_done",  int'(o_done), 0);
        chk("abort_valid", int'(o_out_valid), 0);
        chk("abort_idx",   int'(o_out_idx), 0);
        chk("abort_coeff", int'(o_out_coeff), 0);
        chk("abort_addr",  int'(o_a_addr) + int'(o_b_addr), 0);
        i_reset = 1'b0;
        begin
            int bad = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge i_clk);
                if (o_done || o_out_valid || o_busy) bad++;
            end
            chk("abort_quiet", bad, 0);
        end
        run(1, -1, 0, -1, 1'b0);

        // Start held through DONE: second run begins in the first IDLE cycle.
        run(1, -1, 0, -1, 1'b1);
        chk("held_start_restarts", int'(i_start), 1);
        run(2, -1, 0, -1, 1'b0);
        begin
            int extra = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge i_clk);
                if (o_busy) extra++;
            end
            chk("exactly_two_runs", extra, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/poly_mul_seq.md
# poly_mul_seq

Sequencing controller for the basic polynomial multiplier: on `start` it schedules every coefficient product of two N-term operands over a single shared multiply-accumulate slot, in product-scanning order. It emits the 2N-1 result coefficients one per handshake. Operand storage sits outside the block behind combinational read ports; the controller owns addressing, accumulation and the output stream.

## Interface
- `N`, 4: coefficients per operand (N ≥ 2)
- `W`, 4: coefficient width; all arithmetic mod 2^W
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a multiplication; sampled only in IDLE
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse after the final coefficient handshake
- `a_addr` out clog2(N): operand A read index
- `a_data` in W: A[a_addr], combinational, same cycle
- `b_addr` out clog2(N): operand B read index
- `b_data` in W: B[b_addr], combinational, same cycle
- `out_valid` out 1: result coefficient available
- `out_ready` in 1: consumer accepts the coefficient
- `out_idx` out clog2(2N-1): result coefficient index k
- `out_coeff` out W: result coefficient C[k]

## Operation
- C[k] = Σ A[i]·B[k-i] mod 2^W for k = 0..2N-2, with i running from max(0,k-N+1) to min(k,N-1).
- State machine states:
  - IDLE: waits for `start`. On `start`, sets k=0, i=0 and goes to MAC. `start` is ignored in every other state.
  - MAC: drives `a_addr`=i and `b_addr`=k-i. Each cycle updates acc: acc ← product on the first term of k, otherwise acc ← acc + A[i]·B[k-i]. Both cases truncate to W bits. When i = min(k,N-1), goes to EMIT; otherwise i++.
  - EMIT: `out_valid`=1, `out_idx`=k, `out_coeff`=acc, all held stable until `out_ready`. On the handshake:
    - if k = 2N-2, goes to DONE;
    - otherwise k++, i=max(0,k+1-N+1), and goes to MAC.
  - DONE: `done`=1 for this cycle only, then goes to IDLE.
- Outside MAC, `a_addr`/`b_addr` = 0, and `a_data`/`b_data` are ignored.
- Outside EMIT, `out_valid`=0, `out_idx`=0 and `out_coeff`=0.
- The product is the full 2W-bit value truncated to W bits; the accumulator is W bits and wraps silently.
- Operands must be stable from `start` until `done`. The block does not latch them.
- A `reset` mid-operation aborts the run:
  - the next cycle is IDLE;
  - acc, k and i are cleared;
  - no `done` pulse and no partial coefficient is emitted.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_idx`=0, `out_coeff`=0, `a_addr`=0, `b_addr`=0.
- `start` is sampled at edge t0. MAC begins in cycle t0+1. The number of MAC cycles for coefficient k is min(k,N-1) - max(0,k-N+1) + 1.
- The first `out_valid` (k=0) appears in cycle t0+2.
- Per coefficient there is exactly one EMIT cycle when `out_ready`=1. Each low-`out_ready` cycle adds one stall cycle; there is no MAC progress during a stall.
- Total with `out_ready` held high: N² MAC + (2N-1) EMIT + 1 DONE cycles. For N=4 this is 16+7+1=24, so `done` is high in cycle t0+24 and `busy` falls in cycle t0+25.
- `start` in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted (back-to-back).
- `out_ready` asserted outside EMIT has no effect.

## Test plan
- Simple product: A=[2,3,0,0], B=[1,1,0,0], `out_ready`=1 → C=[2,5,3,0,0,0,0], `out_idx` 0..6 in order, `done` at t0+24.
- Wrap: A=[1,2,3,4], B=[5,6,7,8] → C=[5,0,2,12,13,4,0].
- Saturating operands: A=B=[15,15,15,15] → C=[1,2,3,4,3,2,1].
- Backpressure:
  - Stimulus: A=[1,2,3,4], B=[5,6,7,8]; `out_ready` low for 3 cycles at k=3.
  - Required: `out_valid`, `out_idx`=3 and `out_coeff`=12 held stable throughout the stall; `a_addr`/`b_addr` stay 0; `done` is delayed by 3 cycles.
- Reset mid-run:
  - Stimulus: assert `reset` during MAC of k=2.
  - Required: next cycle `busy`=0, all outputs 0, no `done`.
  - A fresh `start` then yields a correct full result.
- Start handling:
  - `start` pulsed while `busy` → ignored; the result is unchanged.
  - `start` held high through DONE → exactly two runs back-to-back, the second starting from the first IDLE cycle.
